// File: rtl/rv32_fetch_pkg.sv
// Shared definitions for the RV32IM fetch stage: FSM states and fetch constants.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline payload register with load / hold / bubble controls.
module if_id_register
  import rv32_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] ifIdPc,
  output logic [31:0] ifIdPcPlus4,
  output logic [31:0] ifIdInstruction,
  output logic        ifIdValid
);

  // A bubble matches the reset payload, so a bubble always reads PC 0 / NOP.
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      ifIdPc          <= '0;
      ifIdInstruction <= NOP_INSTR;
      ifIdValid       <= 1'b0;
    end else if (load) begin
      ifIdPc          <= pc;
      ifIdInstruction <= instr;
      ifIdValid       <= 1'b1;
    end
  end

  assign ifIdPcPlus4 = ifIdPc + PC_STEP;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: PC, next-PC mux, fetch FSM and IF/ID capture.
// Optional macro FETCH_PERF_COUNTER_EN adds the fetchCount output.
module instruction_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [31:0] pcAddress,
  input  logic [31:0] instruction,
  output logic [31:0] ifIdPc,
  output logic [31:0] ifIdPcPlus4,
  output logic [31:0] ifIdInstruction,
  output logic        ifIdValid,
  output logic        fetchFault,
  output logic [31:0] faultAddress
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0] fetchCount
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_next;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         fault_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= BOOT;
      pcAddress    <= RESET_VECTOR;
      fetchFault   <= 1'b0;
      faultAddress <= '0;
    end else begin
      state     <= state_next;
      pcAddress <= pc_next;
      if (fault_set) begin
        fetchFault   <= 1'b1;
        faultAddress <= branchTarget;
      end
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pcAddress;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    fault_set   = 1'b0;
    case (state)
      BOOT, RUN: begin
        if (branchTaken) begin
          ifid_bubble = 1'b1;
          if (branchTarget[1:0] == 2'b00) begin
            pc_next    = branchTarget;
            state_next = RUN;
          end else begin
            fault_set  = 1'b1;
            state_next = FAULT;
          end
        end else if (state == BOOT) begin
          // BOOT never captures; a stall simply keeps the FSM in BOOT.
          ifid_bubble = 1'b1;
          if (!stall) state_next = RUN;
        end else if (stall) begin
          state_next = RUN;
        end else if (flush) begin
          ifid_bubble = 1'b1;
          pc_next     = pcAddress + PC_STEP;
        end else begin
          ifid_load = 1'b1;
          pc_next   = pcAddress + PC_STEP;
        end
      end
      FAULT: begin
        ifid_bubble = 1'b1;
      end
      default: begin
        state_next  = FAULT;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  if_id_register u_if_id (
    .clk             (clk),
    .reset           (reset),
    .load            (ifid_load),
    .bubble          (ifid_bubble),
    .pc              (pcAddress),
    .instr           (instruction),
    .ifIdPc          (ifIdPc),
    .ifIdPcPlus4     (ifIdPcPlus4),
    .ifIdInstruction (ifIdInstruction),
    .ifIdValid       (ifIdValid)
  );

`ifdef FETCH_PERF_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetchCount <= '0;
    end else if (ifid_load) begin
      fetchCount <= fetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory model returns 32'hA000_0000 | address.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] pcAddress;
  logic [31:0] instruction;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdPcPlus4;
  logic [31:0] ifIdInstruction;
  logic        ifIdValid;
  logic        fetchFault;
  logic [31:0] faultAddress;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetchCount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign instruction = 32'hA000_0000 | pcAddress;

  instruction_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .branchTaken     (branchTaken),
    .branchTarget    (branchTarget),
    .pcAddress       (pcAddress),
    .instruction     (instruction),
    .ifIdPc          (ifIdPc),
    .ifIdPcPlus4     (ifIdPcPlus4),
    .ifIdInstruction (ifIdInstruction),
    .ifIdValid       (ifIdValid),
    .fetchFault      (fetchFault),
    .faultAddress    (faultAddress)
`ifdef FETCH_PERF_COUNTER_EN
    ,
    .fetchCount      (fetchCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pcAddress, 32'h0);
    check({tag, "_ifpc"}, ifIdPc, 32'h0);
    check({tag, "_ifpc4"}, ifIdPcPlus4, 32'h4);
    check({tag, "_instr"}, ifIdInstruction, 32'h13);
    check({tag, "_valid"}, {31'b0, ifIdValid}, 32'h0);
    check({tag, "_fault"}, {31'b0, fetchFault}, 32'h0);
    check({tag, "_faddr"}, faultAddress, 32'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    branchTaken = 1'b0; branchTarget = '0;
    step();
    check_reset_state("rst");
    step();
    check_reset_state("rst_hold");

    // Release: BOOT edge, then first capture.
    reset = 1'b1;
    step();
    check("boot_pc", pcAddress, 32'h0);
    check("boot_valid", {31'b0, ifIdValid}, 32'h0);
    step();
    check("run1_pc", pcAddress, 32'h4);
    check("run1_ifpc", ifIdPc, 32'h0);
    check("run1_instr", ifIdInstruction, 32'hA000_0000);
    check("run1_valid", {31'b0, ifIdValid}, 32'h1);
    step();
    check("run2_pc", pcAddress, 32'h8);
    check("run2_ifpc", ifIdPc, 32'h4);
    check("run2_ifpc4", ifIdPcPlus4, 32'h8);

    // Stall 3 cycles at pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pcAddress, 32'h8);
      check("stall_ifpc", ifIdPc, 32'h4);
      check("stall_valid", {31'b0, ifIdValid}, 32'h1);
    end
`ifdef FETCH_PERF_COUNTER_EN
    check("cnt_stall", fetchCount, 32'd2);
`endif
    stall = 1'b0;
    step();
    check("resume_pc", pcAddress, 32'hC);
    check("resume_ifpc", ifIdPc, 32'h8);
    check("resume_instr", ifIdInstruction, 32'hA000_0008);

    // Redirect coincident with stall: redirect wins.
    branchTaken = 1'b1; branchTarget = 32'h40; stall = 1'b1;
    step();
    check("br_pc", pcAddress, 32'h40);
    check("br_instr", ifIdInstruction, 32'h13);
    check("br_valid", {31'b0, ifIdValid}, 32'h0);
    branchTaken = 1'b0; stall = 1'b0;
    step();
    check("br_tgt_ifpc", ifIdPc, 32'h40);
    check("br_tgt_instr", ifIdInstruction, 32'hA000_0040);
    check("br_tgt_valid", {31'b0, ifIdValid}, 32'h1);
    check("br_tgt_pc", pcAddress, 32'h44);

    // Flush: PC advances, bubble captured.
    flush = 1'b1;
    step();
    check("fl_pc", pcAddress, 32'h48);
    check("fl_valid", {31'b0, ifIdValid}, 32'h0);
    check("fl_instr", ifIdInstruction, 32'h13);
    flush = 1'b0;
    step();
    check("fl_next_ifpc", ifIdPc, 32'h48);
    check("fl_next_valid", {31'b0, ifIdValid}, 32'h1);

    // Wrap at the top of the address space.
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
    step();
    check("wrap_br_pc", pcAddress, 32'hFFFF_FFFC);
    branchTaken = 1'b0;
    step();
    check("wrap_pc", pcAddress, 32'h0);
    check("wrap_ifpc", ifIdPc, 32'hFFFF_FFFC);
    check("wrap_ifpc4", ifIdPcPlus4, 32'h0);
    check("wrap_fault", {31'b0, fetchFault}, 32'h0);
    step();
    check("wrap2_pc", pcAddress, 32'h4);
    check("wrap2_ifpc", ifIdPc, 32'h0);
`ifdef FETCH_PERF_COUNTER_EN
    check("cnt_total", fetchCount, 32'd7);
`endif

    // Misaligned redirect traps; FAULT ignores further inputs.
    branchTaken = 1'b1; branchTarget = 32'h42;
    step();
    check("flt_fault", {31'b0, fetchFault}, 32'h1);
    check("flt_faddr", faultAddress, 32'h42);
    check("flt_pc", pcAddress, 32'h4);
    check("flt_valid", {31'b0, ifIdValid}, 32'h0);
    branchTarget = 32'h80;
    step();
    check("flt_hold_pc", pcAddress, 32'h4);
    check("flt_hold_faddr", faultAddress, 32'h42);
    check("flt_hold_valid", {31'b0, ifIdValid}, 32'h0);
    branchTaken = 1'b0;
    step();
    check("flt_hold2_pc", pcAddress, 32'h4);
    check("flt_hold2_fault", {31'b0, fetchFault}, 32'h1);

    // Reset in FAULT wins, even with a redirect pending.
    reset = 1'b0; branchTaken = 1'b1; branchTarget = 32'h100;
    step();
    check_reset_state("rst_flt");
`ifdef FETCH_PERF_COUNTER_EN
    check("cnt_rst", fetchCount, 32'd0);
`endif

    // Stall in BOOT delays the move to RUN.
    branchTaken = 1'b0; stall = 1'b1; reset = 1'b1;
    step();
    check("bstall1_pc", pcAddress, 32'h0);
    check("bstall1_valid", {31'b0, ifIdValid}, 32'h0);
    stall = 1'b0;
    step();
    check("bstall2_valid", {31'b0, ifIdValid}, 32'h0);
    check("bstall2_pc", pcAddress, 32'h0);
    step();
    check("bstall3_valid", {31'b0, ifIdValid}, 32'h1);
    check("bstall3_ifpc", ifIdPc, 32'h0);
    check("bstall3_pc", pcAddress, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
